// File: rtl/fp_cvt128_to96.sv
// fp_cvt128_to96: two-stage pipelined FP128 -> FP96 narrowing converter
// with IEEE rounding modes and inexact/overflow/invalid flags.
`default_nettype none

module fp_cvt128_to96 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [127:0] i,
  input  logic [2:0]   rm,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [95:0]  o,
  output logic         o_nx,
  output logic         o_ov,
  output logic         o_nv
);

  localparam logic [1:0] CLS_FIN  = 2'd0;
  localparam logic [1:0] CLS_INF  = 2'd1;
  localparam logic [1:0] CLS_QNAN = 2'd2;
  localparam logic [1:0] CLS_SNAN = 2'd3;

  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic [14:0] EXP_MAX = 15'h7FFF;

  logic        v1, v2;
  logic        adv1, adv2;

  logic        s1_sign;
  logic [94:0] s1_mag;
  logic [2:0]  s1_rm;
  logic [1:0]  s1_cls;
  logic        s1_guard, s1_sticky, s1_lsb;

  logic [95:0] s2_res;
  logic        s2_nx, s2_ov, s2_nv;

  logic [1:0]  in_cls;
  logic        inc;
  logic [94:0] sum;
  logic [95:0] res;
  logic        nx, ov, nv;

  assign adv2    = ~v2 | o_ready;
  assign adv1    = ~v1 | adv2;
  assign i_ready = adv1;

  always_comb begin
    in_cls = CLS_FIN;
    if (&i[126:112]) begin
      if (i[111:0] == 112'd0) in_cls = CLS_INF;
      else if (i[111])        in_cls = CLS_QNAN;
      else                    in_cls = CLS_SNAN;
    end
  end

  // Stage 2 rounding: carry out of the significand ripples into the exponent.
  always_comb begin
    inc = 1'b0;
    case (s1_rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1_sign & (s1_guard | s1_sticky);
      RM_RUP:  inc = ~s1_sign & (s1_guard | s1_sticky);
      RM_RMM:  inc = s1_guard;
      default: inc = s1_guard & (s1_sticky | s1_lsb);
    endcase

    sum = s1_mag + {94'd0, inc};
    res = {s1_sign, sum};
    nx  = s1_guard | s1_sticky;
    ov  = 1'b0;
    nv  = 1'b0;

    case (s1_cls)
      CLS_INF: begin
        res = {s1_sign, EXP_MAX, 80'd0};
        nx  = 1'b0;
      end
      CLS_QNAN, CLS_SNAN: begin
        res = {s1_sign, EXP_MAX, 1'b1, s1_mag[78:0]};
        nx  = 1'b0;
        nv  = (s1_cls == CLS_SNAN);
      end
      default: begin
        if (sum[94:80] == EXP_MAX) ov = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      s1_sign   <= 1'b0;
      s1_mag    <= '0;
      s1_rm     <= '0;
      s1_cls    <= CLS_FIN;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_lsb    <= 1'b0;
      s2_res    <= '0;
      s2_nx     <= 1'b0;
      s2_ov     <= 1'b0;
      s2_nv     <= 1'b0;
    end else begin
      if (adv1) v1 <= i_valid;
      if (adv2) v2 <= v1;

      if (adv1 && i_valid) begin
        s1_sign   <= i[127];
        s1_mag    <= {i[126:112], i[111:32]};
        s1_rm     <= rm;
        s1_cls    <= in_cls;
        s1_guard  <= i[31];
        s1_sticky <= |i[30:0];
        s1_lsb    <= i[32];
      end

      if (adv2 && v1) begin
        s2_res <= res;
        s2_nx  <= nx;
        s2_ov  <= ov;
        s2_nv  <= nv;
      end
    end
  end

  // Outputs are forced to zero whenever no result is being presented.
  assign o_valid = v2;
  assign o       = v2 ? s2_res : 96'd0;
  assign o_nx    = v2 & s2_nx;
  assign o_ov    = v2 & s2_ov;
  assign o_nv    = v2 & s2_nv;

endmodule

`default_nettype wire

// File: tb/tb_fp_cvt128_to96.sv
// tb_fp_cvt128_to96: directed vector table, randomized stream against a
// behavioural model, back-pressure hold and asynchronous reset sequences.
`default_nettype none

module tb_fp_cvt128_to96;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid;
  logic         i_ready;
  logic [127:0] i;
  logic [2:0]   rm;
  logic         o_valid;
  logic         o_ready;
  logic [95:0]  o;
  logic         o_nx, o_ov, o_nv;

  fp_cvt128_to96 dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i(i), .rm(rm),
    .o_valid(o_valid), .o_ready(o_ready), .o(o), .o_nx(o_nx), .o_ov(o_ov), .o_nv(o_nv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] a;
    logic [2:0]   m;
    logic [95:0]  res;
    logic [2:0]   flg;   // {nx, ov, nv}
  } vec_t;

  int checks = 0;
  int failures = 0;
  int n_out = 0;
  logic [98:0] exp_q[$];
  logic        hold_prev = 1'b0;
  logic [98:0] prev_out;

  // Reference: round from the numeric value of the discarded 32-bit remainder.
  function automatic logic [98:0] model(input logic [127:0] a, input logic [2:0] m);
    logic        s;
    logic [14:0] e;
    logic [111:0] f;
    logic [79:0] kept;
    logic [31:0] rem;
    logic        up;
    logic [94:0] mag;
    s = a[127]; e = a[126:112]; f = a[111:0];
    kept = f[111:32]; rem = f[31:0];
    if (e == 15'h7FFF) begin
      if (f == 112'd0) return {s, 15'h7FFF, 80'd0, 3'b000};
      return {s, 15'h7FFF, 1'b1, f[110:32], 2'b00, ~f[111]};
    end
    case (m)
      3'd1:    up = 1'b0;
      3'd2:    up = s && (rem != 0);
      3'd3:    up = !s && (rem != 0);
      3'd4:    up = (rem >= 32'h8000_0000);
      default: up = (rem > 32'h8000_0000) || ((rem == 32'h8000_0000) && kept[0]);
    endcase
    mag = {e, kept} + (up ? 95'd1 : 95'd0);
    return {s, mag, (rem != 0), (mag[94:80] == 15'h7FFF), 1'b0};
  endfunction

  function automatic logic [127:0] rand_op();
    logic [127:0] a;
    a = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 9))
      0: a[126:112] = 15'h7FFF;
      1: begin a[126:112] = 15'h7FFF; a[111:0] = '0; end
      2: a[126:112] = 15'h0000;
      3: begin a[126:112] = 15'h7FFE; a[111:32] = '1; end
      4: a[31:0] = 32'h8000_0000;
      5: a[31:0] = 32'h0000_0000;
      6: a[126:0] = '0;
      default: ;
    endcase
    return a;
  endfunction

  task automatic step(input logic v, input logic [127:0] a, input logic [2:0] m,
                      input logic ordy, output logic acc);
    logic [98:0] got, want;
    @(negedge clk);
    i_valid = v; i = a; rm = m; o_ready = ordy;
    #1;
    got = {o, o_nx, o_ov, o_nv};
    if (hold_prev) begin
      checks++;
      if (!o_valid || got !== prev_out) begin
        failures++;
        $display("FAIL hold: got valid=%b out=%h, want valid=1 out=%h", o_valid, got, prev_out);
      end
    end
    if (o_valid && o_ready) begin
      checks++;
      n_out++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got out=%h, want no result", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL result: got o=%h nx/ov/nv=%b, want o=%h nx/ov/nv=%b",
                   got[98:3], got[2:0], want[98:3], want[2:0]);
        end
      end
    end
    hold_prev = o_valid && !o_ready;
    prev_out  = got;
    acc = v && i_ready;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  vec_t tbl[15];
  logic acc;
  int   cnt, sent;
  logic [127:0] a;
  logic [2:0]   m;

  initial begin
    tbl[0]  = '{128'h3FFF_0000_0000_0000_0000_0000_0000_0000, 3'd0, 96'h3FFF_0000_0000_0000_0000_0000, 3'b000};
    tbl[1]  = '{128'h3FFF_0000_0000_0000_0000_0000_8000_0000, 3'd0, 96'h3FFF_0000_0000_0000_0000_0000, 3'b100};
    tbl[2]  = '{128'h3FFF_0000_0000_0000_0000_0000_8000_0000, 3'd4, 96'h3FFF_0000_0000_0000_0000_0001, 3'b100};
    tbl[3]  = '{128'h7FFE_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 3'd0, 96'h7FFF_0000_0000_0000_0000_0000, 3'b110};
    tbl[4]  = '{128'h7FFE_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 3'd1, 96'h7FFE_FFFF_FFFF_FFFF_FFFF_FFFF, 3'b100};
    tbl[5]  = '{128'h7FFF_0000_0000_0000_0000_0000_0000_0001, 3'd0, 96'h7FFF_8000_0000_0000_0000_0000, 3'b001};
    tbl[6]  = '{128'hFFFF_0000_0000_0000_0000_0000_0000_0000, 3'd3, 96'hFFFF_0000_0000_0000_0000_0000, 3'b000};
    tbl[7]  = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 3'd2, 96'h8000_0000_0000_0000_0000_0000, 3'b000};
    tbl[8]  = '{128'h7FFF_C000_0000_0000_0000_0000_0000_0000, 3'd0, 96'h7FFF_C000_0000_0000_0000_0000, 3'b000};
    tbl[9]  = '{128'h0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 3'd3, 96'h0001_0000_0000_0000_0000_0000, 3'b100};
    tbl[10] = '{128'hBFFF_0000_0000_0000_0000_0000_0000_0001, 3'd2, 96'hBFFF_0000_0000_0000_0000_0001, 3'b100};
    tbl[11] = '{128'h3FFF_0000_0000_0000_0000_0000_0000_0001, 3'd2, 96'h3FFF_0000_0000_0000_0000_0000, 3'b100};
    tbl[12] = '{128'h3FFF_0000_0000_0000_0000_0001_8000_0000, 3'd0, 96'h3FFF_0000_0000_0000_0000_0002, 3'b100};
    tbl[13] = '{128'h3FFF_0000_0000_0000_0000_0001_8000_0000, 3'd7, 96'h3FFF_0000_0000_0000_0000_0002, 3'b100};
    tbl[14] = '{128'h3FFF_0000_0000_0000_0000_8000_0000_0000, 3'd0, 96'h3FFF_0000_0000_0000_0000_8000, 3'b000};

    rst_n = 1'b0; i_valid = 1'b0; i = '0; rm = '0; o_ready = 1'b1;
    #1;
    check("reset_o_valid", {127'd0, o_valid}, 128'd0);
    check("reset_o", {32'd0, o}, 128'd0);
    check("reset_flags", {125'd0, o_nx, o_ov, o_nv}, 128'd0);
    check("reset_i_ready", {127'd0, i_ready}, 128'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, one at a time, with latency check.
    for (int k = 0; k < 15; k++) begin
      step(1'b1, tbl[k].a, tbl[k].m, 1'b1, acc);
      check("accept", {127'd0, acc}, 128'd1);
      if (acc) exp_q.push_back({tbl[k].res, tbl[k].flg});
      step(1'b0, '0, '0, 1'b1, acc);
      check("latency_early", {127'd0, o_valid}, 128'd0);
      step(1'b0, '0, '0, 1'b1, acc);
      check("latency_due", {96'd0, 32'(exp_q.size())}, 128'd0);
    end

    // Full throughput with o_ready held high.
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      a = rand_op(); m = 3'($urandom_range(0, 7));
      step(1'b1, a, m, 1'b1, acc);
      if (acc) begin exp_q.push_back(model(a, m)); cnt++; end
    end
    check("throughput", 128'(cnt), 128'd6);

    // Eight back-to-back operands under random back-pressure, then a longer random mix.
    sent = 0;
    for (int c = 0; c < 400 && sent < 8; c++) begin
      a = rand_op(); m = 3'($urandom_range(0, 7));
      step(1'b1, a, m, 1'($urandom_range(0, 1)), acc);
      if (acc) begin exp_q.push_back(model(a, m)); sent++; end
    end
    check("stream8_sent", 128'(sent), 128'd8);
    sent = 0;
    for (int c = 0; c < 4000 && sent < 300; c++) begin
      a = rand_op(); m = 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 3) != 0), a, m, 1'($urandom_range(0, 2) != 0), acc);
      if (acc) begin exp_q.push_back(model(a, m)); sent++; end
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) step(1'b0, '0, '0, 1'b1, acc);
    check("drain_empty", 128'(exp_q.size()), 128'd0);

    // Fill both stages under stall, then reset asynchronously mid-cycle.
    step(1'b1, tbl[0].a, 3'd0, 1'b0, acc);
    step(1'b1, tbl[3].a, 3'd0, 1'b0, acc);
    step(1'b0, '0, '0, 1'b0, acc);
    check("full_o_valid", {127'd0, o_valid}, 128'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_o_valid", {127'd0, o_valid}, 128'd0);
    check("async_rst_o", {32'd0, o}, 128'd0);
    check("async_rst_i_ready", {127'd0, i_ready}, 128'd1);
    exp_q.delete();
    hold_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = n_out;
    step(1'b1, tbl[9].a, tbl[9].m, 1'b1, acc);
    if (acc) exp_q.push_back({tbl[9].res, tbl[9].flg});
    for (int c = 0; c < 8; c++) step(1'b0, '0, '0, 1'b1, acc);
    check("post_reset_count", 128'(n_out - cnt), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
